// File: rtl/imem_loader.sv
// imem_loader: receives a framed byte stream and writes little-endian 32-bit words into instruction memory.
module imem_loader #(
    parameter int          DEPTH = 16,
    parameter logic [7:0]  MAGIC = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        write,
    output logic [31:0] addr_in,
    output logic [31:0] data,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {IDLE, CNT_LO, CNT_HI, DATA, CHK, DONE, ERR} state_t;

    state_t      state, nxt;
    logic [7:0]  cnt_lo;
    logic [15:0] count;
    logic [15:0] word_idx;
    logic [1:0]  byte_idx;
    logic [23:0] asm_word;
    logic [7:0]  chk;
    logic [15:0] cnt_full;

    assign cnt_full = {in_data, cnt_lo};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt = state;
        if (in_valid) begin
            case (state)
                IDLE, DONE, ERR: nxt = in_data == MAGIC ? CNT_LO : state;
                CNT_LO:          nxt = CNT_HI;
                CNT_HI:          nxt = cnt_full > 16'(DEPTH) ? ERR : cnt_full == 16'd0 ? CHK : DATA;
                DATA:            nxt = byte_idx == 2'd3 && word_idx + 16'd1 == count ? CHK : DATA;
                CHK:             nxt = in_data == chk ? DONE : ERR;
                default:         nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready = 1'b1;
        cpu_hold = !(state == IDLE || state == DONE);
        done     = state == DONE;
        error    = state == ERR;
    end

    // Bytes shift in from the top so the first byte ends up in the least significant lane.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write    <= 1'b0;
            addr_in  <= '0;
            data     <= '0;
            cnt_lo   <= '0;
            count    <= '0;
            word_idx <= '0;
            byte_idx <= '0;
            asm_word <= '0;
            chk      <= '0;
        end else begin
            write <= 1'b0;
            if (in_valid) begin
                case (state)
                    IDLE, DONE, ERR: begin
                        if (in_data == MAGIC) begin
                            chk      <= '0;
                            byte_idx <= '0;
                            word_idx <= '0;
                        end
                    end
                    CNT_LO: cnt_lo <= in_data;
                    CNT_HI: count  <= cnt_full;
                    DATA: begin
                        asm_word <= {in_data, asm_word[23:8]};
                        chk      <= chk + in_data;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            write    <= 1'b1;
                            data     <= {in_data, asm_word};
                            addr_in  <= 32'(word_idx[AW-1:0]);
                            word_idx <= word_idx + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed frames checked every cycle against a queue-based frame parser model.
module tb_imem_loader;
    localparam int         DEPTH = 16;
    localparam logic [7:0] MAGIC = 8'hA5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, write, cpu_hold, done, error;
    logic [31:0] addr_in, data;

    int checks = 0;
    int errors = 0;
    bit gaps = 0;

    imem_loader #(.DEPTH(DEPTH), .MAGIC(MAGIC)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .write(write), .addr_in(addr_in), .data(data),
        .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: gathers bytes of the current frame and decides outcomes from frame position.
    logic [7:0]  frm[$];
    logic        active;
    logic        m_write, m_hold, m_done, m_err;
    logic [31:0] m_addr, m_data;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            frm.delete();
            active  <= 1'b0;
            m_write <= 1'b0;
            m_hold  <= 1'b0;
            m_done  <= 1'b0;
            m_err   <= 1'b0;
            m_addr  <= '0;
            m_data  <= '0;
        end else begin
            m_write <= 1'b0;
            if (in_valid) begin
                if (!active) begin
                    if (in_data == MAGIC) begin
                        frm.delete();
                        active <= 1'b1;
                        m_hold <= 1'b1;
                        m_done <= 1'b0;
                        m_err  <= 1'b0;
                    end
                end else begin
                    int sz, n;
                    logic [7:0] sum;
                    frm.push_back(in_data);
                    sz = frm.size();
                    n = sz >= 2 ? int'({frm[1], frm[0]}) : 0;
                    if (sz == 2 && n > DEPTH) begin
                        active <= 1'b0;
                        m_err  <= 1'b1;
                    end else if (sz > 2 && sz <= 2 + 4 * n && (sz - 2) % 4 == 0) begin
                        m_write <= 1'b1;
                        m_addr  <= 32'((sz - 2) / 4 - 1);
                        m_data  <= {frm[sz-1], frm[sz-2], frm[sz-3], frm[sz-4]};
                    end else if (sz > 2 && sz == 3 + 4 * n) begin
                        sum = 8'h00;
                        for (int i = 2; i < 2 + 4 * n; i++) sum = sum + frm[i];
                        active <= 1'b0;
                        if (sum == in_data) begin
                            m_done <= 1'b1;
                            m_hold <= 1'b0;
                        end else m_err <= 1'b1;
                    end
                end
            end
        end
    end

    logic [31:0] wlog_a[$], wlog_d[$];

    always @(negedge clk) begin
        check("in_ready", in_ready, 1);
        check("write", write, m_write);
        check("addr_in", addr_in, m_addr);
        check("data", data, m_data);
        check("cpu_hold", cpu_hold, m_hold);
        check("done", done, m_done);
        check("error", error, m_err);
        if (write) begin
            wlog_a.push_back(addr_in);
            wlog_d.push_back(data);
        end
    end

    logic [7:0] tx[$];

    task automatic send(input logic [7:0] b);
        if (gaps) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_tx();
        foreach (tx[i]) send(tx[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_good_log(input string tag);
        logic [31:0] ea[5] = '{0, 1, 2, 3, 4};
        logic [31:0] ed[5] = '{32'h00100093, 32'h01809093, 32'h01008093, 32'h0080A023, 32'hFFDFF06F};
        check({tag, "_nwrites"}, wlog_a.size(), 5);
        for (int i = 0; i < 5 && i < wlog_a.size(); i++) begin
            check({tag, "_addr"}, wlog_a[i], ea[i]);
            check({tag, "_data"}, wlog_d[i], ed[i]);
        end
    endtask

    task automatic good_frame(input logic [7:0] last);
        tx = '{8'hA5, 8'h05, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h93, 8'h90, 8'h80, 8'h01,
               8'h93, 8'h80, 8'h00, 8'h01, 8'h23, 8'hA0, 8'h80, 8'h00, 8'h6F, 8'hF0, 8'hDF, 8'hFF};
        tx.push_back(last);
        send_tx();
    endtask

    initial begin
        idle(2);
        check("rst_ready", in_ready, 1);
        check("rst_write", write, 0);
        check("rst_addr", addr_in, 0);
        check("rst_data", data, 0);
        check("rst_hold", cpu_hold, 0);
        check("rst_done", done, 0);
        check("rst_err", error, 0);
        reset = 1'b0;
        idle(2);

        // Good load
        wlog_a.delete(); wlog_d.delete();
        good_frame(8'hDB);
        idle(2);
        check_good_log("good");
        check("good_done", done, 1);
        check("good_err", error, 0);
        check("good_hold", cpu_hold, 0);

        // Bad checksum
        wlog_a.delete(); wlog_d.delete();
        good_frame(8'hDC);
        idle(2);
        check_good_log("badchk");
        check("badchk_done", done, 0);
        check("badchk_err", error, 1);
        check("badchk_hold", cpu_hold, 1);

        // Oversize count, ignored bytes, then empty frame
        wlog_a.delete(); wlog_d.delete();
        tx = '{8'hA5, 8'h11, 8'h00};
        send_tx();
        check("over_err", error, 1);
        tx = '{8'h12, 8'h34};
        send_tx();
        check("over_still_err", error, 1);
        tx = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_tx();
        idle(1);
        check("empty_done", done, 1);
        check("empty_err", error, 0);
        check("over_nwrites", wlog_a.size(), 0);

        // Noise and gaps
        wlog_a.delete(); wlog_d.delete();
        gaps = 1;
        tx = '{8'h00, 8'hFF};
        send_tx();
        good_frame(8'hDB);
        gaps = 0;
        idle(2);
        check_good_log("gaps");
        check("gaps_done", done, 1);

        // Reset in the middle of a word
        wlog_a.delete(); wlog_d.delete();
        tx = '{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00};
        send_tx();
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_hold", cpu_hold, 0);
        check("mid_rst_write", write, 0);
        check("mid_rst_addr", addr_in, 0);
        check("mid_rst_data", data, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        idle(2);
        check("mid_rst_nwrites", wlog_a.size(), 0);
        good_frame(8'hDB);
        idle(2);
        check_good_log("after_rst");
        check("after_rst_done", done, 1);

        // Back-to-back frames
        wlog_a.delete(); wlog_d.delete();
        good_frame(8'hDB);
        check("b2b_first_done", done, 1);
        send(8'hA5);
        check("b2b_done_clear", done, 0);
        wlog_a.delete(); wlog_d.delete();
        tx = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h14};
        send_tx();
        idle(2);
        check("b2b_nwrites", wlog_a.size(), 1);
        if (wlog_a.size() > 0) begin
            check("b2b_addr", wlog_a[0], 0);
            check("b2b_data", wlog_d[0], 32'h12345678);
        end
        check("b2b_done", done, 1);
        check("b2b_err", error, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
